// File: rtl/btb_predictor_pkg.sv
// Shared constants and types for the IF-stage branch predictor.
package btb_predictor_pkg;

    localparam int BP_WORD_SIZE = 16;
    localparam int BP_IDX_SIZE  = 8;

    localparam int BP_MODE_NONE  = 0;
    localparam int BP_MODE_BTB   = 1;
    localparam int BP_MODE_SAT2  = 2;
    localparam int BP_MODE_HYST2 = 3;

    typedef logic [1:0] bp_cnt_t;

    localparam bp_cnt_t CNT_RESET = 2'b01;
    localparam bp_cnt_t CNT_ALLOC = 2'b10;

endpackage

// File: rtl/btb_predictor_counter_next.sv
// Combinational 2-bit direction counter next-state, selected by prediction mode.
module btb_predictor_counter_next
    import btb_predictor_pkg::*;
#(
    parameter int MODE = BP_MODE_SAT2
) (
    input  bp_cnt_t cnt,
    input  logic    taken,
    output bp_cnt_t cnt_next
);

    bp_cnt_t sat_next;
    bp_cnt_t hyst_next;

    always_comb begin
        sat_next = cnt;
        if (taken && cnt != 2'b11) begin
            sat_next = cnt + 2'b01;
        end else if (!taken && cnt != 2'b00) begin
            sat_next = cnt - 2'b01;
        end
    end

    // Hysteresis: a strong state only weakens one step; a weak state jumps across.
    always_comb begin
        hyst_next = 2'b00;
        case ({taken, cnt})
            3'b1_00: hyst_next = 2'b01;
            3'b1_01: hyst_next = 2'b11;
            3'b1_10: hyst_next = 2'b11;
            3'b1_11: hyst_next = 2'b11;
            3'b0_11: hyst_next = 2'b10;
            default: hyst_next = 2'b00;
        endcase
    end

    assign cnt_next = (MODE == BP_MODE_SAT2)  ? sat_next  :
                      (MODE == BP_MODE_HYST2) ? hyst_next : cnt;

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with per-entry direction counters; zero-latency lookup, trained by resolved branches.
module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int WORD_SIZE    = BP_WORD_SIZE,
    parameter int BTB_IDX_SIZE = BP_IDX_SIZE,
    parameter int MODE         = BP_MODE_SAT2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] pc_if,
    output logic                 tag_match,
    output logic                 predict_taken,
    output logic [WORD_SIZE-1:0] predicted_pc,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict,
    output logic [WORD_SIZE-1:0] num_branch,
    output logic [WORD_SIZE-1:0] num_branch_miss
);

    localparam int ENTRIES = 2 ** BTB_IDX_SIZE;
    localparam int TAG_W   = WORD_SIZE - BTB_IDX_SIZE;

    logic                 valid_reg  [ENTRIES];
    logic [TAG_W-1:0]     tag_reg    [ENTRIES];
    logic [WORD_SIZE-1:0] target_reg [ENTRIES];
    bp_cnt_t              cnt_reg    [ENTRIES];

    logic [WORD_SIZE-1:0] num_branch_reg;
    logic [WORD_SIZE-1:0] num_branch_miss_reg;

    logic [BTB_IDX_SIZE-1:0] rd_idx;
    logic [TAG_W-1:0]        rd_tag;
    logic [BTB_IDX_SIZE-1:0] wr_idx;
    logic [TAG_W-1:0]        wr_tag;
    logic                    wr_hit;
    bp_cnt_t                 wr_cnt_next;

    assign rd_idx = pc_if[BTB_IDX_SIZE-1:0];
    assign rd_tag = pc_if[WORD_SIZE-1:BTB_IDX_SIZE];

    assign tag_match = valid_reg[rd_idx] && (tag_reg[rd_idx] == rd_tag);

    always_comb begin
        case (MODE)
            BP_MODE_NONE: predict_taken = 1'b0;
            BP_MODE_BTB:  predict_taken = tag_match;
            default:      predict_taken = tag_match & cnt_reg[rd_idx][1];
        endcase
    end

    assign predicted_pc = predict_taken ? target_reg[rd_idx] : pc_if + WORD_SIZE'(1);

    assign wr_idx = upd_pc[BTB_IDX_SIZE-1:0];
    assign wr_tag = upd_pc[WORD_SIZE-1:BTB_IDX_SIZE];
    assign wr_hit = valid_reg[wr_idx] && (tag_reg[wr_idx] == wr_tag);

    btb_predictor_counter_next #(
        .MODE (MODE)
    ) u_counter_next (
        .cnt      (cnt_reg[wr_idx]),
        .taken    (upd_taken),
        .cnt_next (wr_cnt_next)
    );

    // Not-taken misses leave the table alone so cold branches cannot evict useful entries.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    valid_reg[gi]  <= 1'b0;
                    tag_reg[gi]    <= '0;
                    target_reg[gi] <= '0;
                    cnt_reg[gi]    <= CNT_RESET;
                end else if (upd_valid && wr_idx == BTB_IDX_SIZE'(gi)) begin
                    if (wr_hit) begin
                        cnt_reg[gi] <= wr_cnt_next;
                        if (upd_taken) begin
                            target_reg[gi] <= upd_target;
                        end
                    end else if (upd_taken) begin
                        valid_reg[gi]  <= 1'b1;
                        tag_reg[gi]    <= wr_tag;
                        target_reg[gi] <= upd_target;
                        cnt_reg[gi]    <= CNT_ALLOC;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_branch_reg      <= '0;
            num_branch_miss_reg <= '0;
        end else if (upd_valid) begin
            if (num_branch_reg != '1) begin
                num_branch_reg <= num_branch_reg + WORD_SIZE'(1);
            end
            if (upd_mispredict && num_branch_miss_reg != '1) begin
                num_branch_miss_reg <= num_branch_miss_reg + WORD_SIZE'(1);
            end
        end
    end

    assign num_branch      = num_branch_reg;
    assign num_branch_miss = num_branch_miss_reg;

endmodule

// File: tb/tb_btb_predictor.sv
// One predictor per mode on shared stimulus, checked against a table-level reference model.
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc_if;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic [15:0] upd_target;
    logic        upd_taken;
    logic        upd_mispredict;

    logic        tm  [4];
    logic        pt  [4];
    logic [15:0] ppc [4];
    logic [15:0] nb  [4];
    logic [15:0] nbm [4];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            btb_predictor #(
                .WORD_SIZE    (16),
                .BTB_IDX_SIZE (8),
                .MODE         (gi)
            ) u_dut (
                .clk             (clk),
                .reset_n         (reset_n),
                .pc_if           (pc_if),
                .tag_match       (tm[gi]),
                .predict_taken   (pt[gi]),
                .predicted_pc    (ppc[gi]),
                .upd_valid       (upd_valid),
                .upd_pc          (upd_pc),
                .upd_target      (upd_target),
                .upd_taken       (upd_taken),
                .upd_mispredict  (upd_mispredict),
                .num_branch      (nb[gi]),
                .num_branch_miss (nbm[gi])
            );
        end
    endgenerate

    // Reference model: one table, counters kept per mode as plain integers.
    bit          m_valid  [256];
    logic [7:0]  m_tag    [256];
    logic [15:0] m_target [256];
    int          m_cnt    [4][256];
    int          m_nb;
    int          m_nbm;

    int errors = 0;
    int checks = 0;

    function automatic int next_cnt(input int mode, input int c, input bit t);
        if (mode == 2) return t ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
        if (mode == 3) return t ? ((c == 0) ? 1 : 3) : ((c == 3) ? 2 : 0);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 8'h00;
            m_target[i] = 16'h0000;
            for (int m = 0; m < 4; m++) m_cnt[m][i] = 1;
        end
        m_nb  = 0;
        m_nbm = 0;
    endtask

    task automatic model_update(input logic [15:0] pc, input logic [15:0] tgt,
                                input bit tk, input bit mis);
        int idx;
        idx = int'(pc[7:0]);
        if (m_valid[idx] && m_tag[idx] == pc[15:8]) begin
            for (int m = 0; m < 4; m++) m_cnt[m][idx] = next_cnt(m, m_cnt[m][idx], tk);
            if (tk) m_target[idx] = tgt;
        end else if (tk) begin
            m_valid[idx]  = 1'b1;
            m_tag[idx]    = pc[15:8];
            m_target[idx] = tgt;
            for (int m = 0; m < 4; m++) m_cnt[m][idx] = 2;
        end
        if (m_nb < 65535) m_nb++;
        if (mis && m_nbm < 65535) m_nbm++;
    endtask

    task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic check_lookup(input string tag);
        int  idx;
        bit  hit;
        bit  tk;
        logic [15:0] exp_pc;
        idx = int'(pc_if[7:0]);
        hit = m_valid[idx] && (m_tag[idx] == pc_if[15:8]);
        for (int m = 0; m < 4; m++) begin
            tk = (m == 0) ? 1'b0 : (m == 1) ? hit : (hit && m_cnt[m][idx] >= 2);
            exp_pc = tk ? m_target[idx] : 16'(pc_if + 16'd1);
            chk($sformatf("%s_m%0d_tag_match", tag, m), 16'(tm[m]), 16'(hit));
            chk($sformatf("%s_m%0d_taken", tag, m), 16'(pt[m]), 16'(tk));
            chk($sformatf("%s_m%0d_pc", tag, m), ppc[m], exp_pc);
        end
    endtask

    task automatic check_stats(input string tag);
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("%s_m%0d_num_branch", tag, m), nb[m], 16'(m_nb));
            chk($sformatf("%s_m%0d_num_miss", tag, m), nbm[m], 16'(m_nbm));
        end
    endtask

    // One clock: lookup is checked before the edge (old contents), stats after it.
    task automatic cycle(input string tag, input logic [15:0] pc, input bit uv,
                         input logic [15:0] upc, input logic [15:0] utgt,
                         input bit utk, input bit umis, input bit check);
        pc_if          = pc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_target     = utgt;
        upd_taken      = utk;
        upd_mispredict = umis;
        #1;
        if (check) begin
            check_lookup(tag);
            $display("%s: pc_if=%h pred_m2=%h upd=%0d upc=%h tgt=%h tk=%0d mis=%0d",
                     tag, pc, ppc[2], uv, upc, utgt, utk, umis);
        end
        @(posedge clk);
        #1;
        if (uv) model_update(upc, utgt, utk, umis);
        if (check) check_stats(tag);
    endtask

    // Idle clock with a fixed fetch PC; caller compares outputs afterwards via last_* copies.
    logic        last_tm  [4];
    logic [15:0] last_ppc [4];
    task automatic peek(input logic [15:0] pc);
        pc_if     = pc;
        upd_valid = 1'b0;
        #1;
        for (int m = 0; m < 4; m++) begin
            last_tm[m]  = tm[m];
            last_ppc[m] = ppc[m];
        end
        check_lookup("peek");
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n        = 1'b0;
        pc_if          = 16'h0010;
        upd_valid      = 1'b0;
        upd_pc         = 16'h0000;
        upd_target     = 16'h0000;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b0;
        model_reset();

        // Reset state
        @(posedge clk);
        #1;
        chk("reset_tag_match", 16'(tm[2]), 16'h0000);
        chk("reset_pred_pc", ppc[2], 16'h0011);
        chk("reset_num_branch", nb[2], 16'h0000);
        chk("reset_num_miss", nbm[2], 16'h0000);
        $display("reset: pc_if=0010 pred=%h tm=%0d", ppc[2], tm[2]);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Allocation, then two not-taken trainings in saturating mode
        cycle("t2_alloc", 16'h0000, 1'b1, 16'h0010, 16'h0040, 1'b1, 1'b0, 1'b1);
        peek(16'h0010);
        chk("t2_hit_tm", 16'(last_tm[2]), 16'h0001);
        chk("t2_hit_pc", last_ppc[2], 16'h0040);
        chk("t2_none_pc", last_ppc[0], 16'h0011);
        cycle("t2_nt1", 16'h0010, 1'b1, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b1);
        cycle("t2_nt2", 16'h0010, 1'b1, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b1);
        peek(16'h0010);
        chk("t2_after_nt_pc", last_ppc[2], 16'h0011);
        chk("t2_after_nt_btb", last_ppc[1], 16'h0040);

        // Hysteresis sequence from the strong-taken state
        cycle("t3_alloc", 16'h0020, 1'b1, 16'h0020, 16'h0077, 1'b1, 1'b0, 1'b1);
        cycle("t3_tk", 16'h0020, 1'b1, 16'h0020, 16'h0077, 1'b1, 1'b0, 1'b1);
        cycle("t3_nt1", 16'h0020, 1'b1, 16'h0020, 16'h0000, 1'b0, 1'b1, 1'b1);
        peek(16'h0020);
        chk("t3_weak_taken", last_ppc[3], 16'h0077);
        cycle("t3_nt2", 16'h0020, 1'b1, 16'h0020, 16'h0000, 1'b0, 1'b1, 1'b1);
        peek(16'h0020);
        chk("t3_strong_nt", last_ppc[3], 16'h0021);
        cycle("t3_tk2", 16'h0020, 1'b1, 16'h0020, 16'h0077, 1'b1, 1'b1, 1'b1);
        peek(16'h0020);
        chk("t3_weak_nt", last_ppc[3], 16'h0021);

        // Aliasing: same index, different tag overwrites
        cycle("t4_alias", 16'h0010, 1'b1, 16'h0110, 16'h0200, 1'b1, 1'b0, 1'b1);
        peek(16'h0010);
        chk("t4_old_tm", 16'(last_tm[2]), 16'h0000);
        chk("t4_old_pc", last_ppc[2], 16'h0011);
        peek(16'h0110);
        chk("t4_new_pc", last_ppc[1], 16'h0200);

        // Same-cycle update and lookup, then the wrap at the top of the address space
        cycle("t5_same", 16'h0030, 1'b1, 16'h0030, 16'h0099, 1'b1, 1'b0, 1'b1);
        chk("t5_old_pc", ppc[2], 16'h0099);
        peek(16'h0030);
        chk("t5_new_pc", last_ppc[2], 16'h0099);
        peek(16'hFFFF);
        chk("t5_wrap_pc", last_ppc[2], 16'h0000);

        // Randomised traffic over a small set of indices and tags
        for (int n = 0; n < 500; n++) begin
            logic [15:0] rpc;
            logic [15:0] rupc;
            rpc  = 16'(($urandom_range(0, 3) << 8) | $urandom_range(0, 15));
            rupc = 16'(($urandom_range(0, 3) << 8) | $urandom_range(0, 15));
            cycle($sformatf("rnd%0d", n), rpc, ($urandom_range(0, 9) < 7), rupc,
                  16'($urandom), ($urandom_range(0, 9) < 6), 1'($urandom), 1'b1);
        end

        // Statistics saturation
        reset_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int n = 0; n < 65537; n++) begin
            cycle("t6_sat", 16'h0050, 1'b1, 16'h0050, 16'h0500, 1'b1, 1'b1, 1'b0);
        end
        check_stats("t6_sat");
        chk("t6_sat_branch", nb[2], 16'hFFFF);
        chk("t6_sat_miss", nbm[3], 16'hFFFF);
        $display("t6_sat: num_branch=%h num_branch_miss=%h", nb[2], nbm[2]);

        // Asynchronous reset with an update pending
        pc_if          = 16'h0050;
        upd_valid      = 1'b1;
        upd_mispredict = 1'b1;
        #1;
        chk("t6_pre_reset_tm", 16'(tm[2]), 16'h0001);
        #1;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("t6_async_tm", 16'(tm[2]), 16'h0000);
        chk("t6_async_pc", ppc[2], 16'h0051);
        check_stats("t6_async");
        @(posedge clk);
        #1;
        chk("t6_held_tm", 16'(tm[1]), 16'h0000);
        check_stats("t6_held");
        $display("t6_reset: tm=%0d pred=%h num_branch=%h", tm[2], ppc[2], nb[2]);
        upd_valid = 1'b0;
        reset_n   = 1'b1;
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
